// File: rtl/fir_stream_driver.sv
// fir_stream_driver
// Streaming front/back end for a 6-tap FIR datapath. Serial samples arrive
// over valid/ready and are shifted into a tap delay line. The taps are
// presented in parallel to the datapath. After the datapath's fixed latency,
// the result is captured and returned over valid/ready. Only one sample is
// in flight at a time.
//
// Optional feature: define FIR_WARMUP_EN to suppress results until TAPS
// samples have been accepted since reset. When it is undefined, the delay
// line is zero-prefilled and every accepted sample produces a result.

module fir_stream_driver #(
   parameter int WIDTH     = 16,
   parameter int TAPS      = 6,
   parameter int OUT_WIDTH = 32,
   parameter int LAT       = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [WIDTH-1:0]        s_data,
   output logic [TAPS*WIDTH-1:0]   taps,
   output logic                    tap_valid,
   input  logic [OUT_WIDTH-1:0]    res_in,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [OUT_WIDTH-1:0]    m_data
);

   localparam logic [7:0] LAT_L = 8'(LAT);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      HOLD
   } state_t;

   state_t                  r_state;
   state_t                  w_nextState;
   logic [TAPS*WIDTH-1:0]   r_taps;
   logic                    r_tapValid;
   logic [7:0]              r_cnt;
   logic                    r_mValid;
   logic [OUT_WIDTH-1:0]    r_mData;
   logic                    w_accept;
   logic                    w_cntDone;
   logic                    w_emit;

   assign w_accept  = s_valid && s_ready;
   assign w_cntDone = (r_state == WAIT) && (r_cnt == 8'd1);

   assign taps      = r_taps;
   assign tap_valid = r_tapValid;
   assign m_valid   = r_mValid;
   assign m_data    = r_mData;

`ifdef FIR_WARMUP_EN
   localparam int WARM_W = (TAPS > 2) ? $clog2(TAPS) : 1;
   localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(TAPS - 1);

   logic [WARM_W-1:0] r_warm;
   logic              r_emit;

   assign w_emit = r_emit;

   // Count accepted samples, saturating. Latch whether the sample being accepted is at least the TAPS-th.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_warm <= '0;
         r_emit <= 1'b0;
      end else if (w_accept) begin
         r_emit <= (r_warm == WARM_MAX);
         if (r_warm != WARM_MAX) begin
            r_warm <= r_warm + 1'b1;
         end
      end
   end
`else
   assign w_emit = 1'b1;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic and input readiness. In HOLD, readiness follows the sink so that take and accept can coincide.
   always_comb begin
      s_ready     = 1'b0;
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            s_ready = !rst;
            if (s_valid && !rst) begin
               w_nextState = WAIT;
            end
         end
         WAIT: begin
            if (w_cntDone) begin
               w_nextState = w_emit ? HOLD : IDLE;
            end
         end
         HOLD: begin
            s_ready = m_ready && !rst;
            if (m_ready) begin
               w_nextState = s_valid ? WAIT : IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Delay line shifts only on an accepted sample. Slice 0 (low bits) holds the newest sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_taps <= '0;
      end else if (w_accept) begin
         r_taps <= {r_taps[(TAPS-1)*WIDTH-1:0], s_data};
      end
   end

   // Pulse tap_valid for one cycle after each accepted sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tapValid <= 1'b0;
      end else begin
         r_tapValid <= w_accept;
      end
   end

   // Latency counter: load on accept and count down through WAIT. Completion is at the count of 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= 8'd0;
      end else if (w_accept) begin
         r_cnt <= LAT_L;
      end else if (r_state == WAIT) begin
         r_cnt <= r_cnt - 8'd1;
      end
   end

   // Capture the datapath result at WAIT completion. Hold it until the sink takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mValid <= 1'b0;
         r_mData  <= '0;
      end else if (w_cntDone && w_emit) begin
         r_mValid <= 1'b1;
         r_mData  <= res_in;
      end else if ((r_state == HOLD) && m_ready) begin
         r_mValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_stream_driver.sv
// Testbench for fir_stream_driver.
// The datapath is modelled as the sum of the taps through LAT-1 register stages.
// The result is therefore settled by the cycle the driver captures it.
// A scoreboard pushes expected sums when samples are accepted and pops them when results are taken.

module tb_fir_stream_driver;

   localparam int WIDTH     = 16;
   localparam int TAPS      = 6;
   localparam int OUT_WIDTH = 32;
   localparam int LAT       = 3;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   s_valid = 1'b0;
   logic                   s_ready;
   logic [WIDTH-1:0]       s_data = '0;
   logic [TAPS*WIDTH-1:0]  taps;
   logic                   tap_valid;
   logic [OUT_WIDTH-1:0]   res_in;
   logic                   m_valid;
   logic                   m_ready = 1'b0;
   logic [OUT_WIDTH-1:0]   m_data;

   int assertCount = 0;
   int failCount   = 0;

   logic [OUT_WIDTH-1:0]   sbQueue[$];
   logic [OUT_WIDTH-1:0]   observed[$];
   logic [WIDTH-1:0]       modelTaps[TAPS];
   int                     acceptCount = 0;
   int                     tapPulses   = 0;
   logic [OUT_WIDTH-1:0]   dpStage[LAT-1];

   fir_stream_driver #(
      .WIDTH(WIDTH), .TAPS(TAPS), .OUT_WIDTH(OUT_WIDTH), .LAT(LAT)
   ) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .taps(taps), .tap_valid(tap_valid), .res_in(res_in),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
   );

   always #5 clk = ~clk;

   // Datapath model: combinational tap sum, then LAT-1 register stages.
   always @(posedge clk) begin
      logic [OUT_WIDTH-1:0] sum;
      sum = '0;
      for (int k = 0; k < TAPS; k++) begin
         sum = sum + OUT_WIDTH'(taps[k*WIDTH +: WIDTH]);
      end
      dpStage[0] <= sum;
      for (int j = 1; j < LAT-1; j++) begin
         dpStage[j] <= dpStage[j-1];
      end
   end
   assign res_in = dpStage[LAT-2];

   function automatic logic [WIDTH-1:0] tapSlice(input int k);
      return taps[k*WIDTH +: WIDTH];
   endfunction

   // Scoreboard monitor, sampled on the falling edge between active edges.
   always @(negedge clk) begin
      logic [OUT_WIDTH-1:0] expSum;
      logic [OUT_WIDTH-1:0] expVal;
      if (rst) begin
         for (int k = 0; k < TAPS; k++) modelTaps[k] = '0;
         sbQueue.delete();
         acceptCount = 0;
      end else begin
         if (m_valid && m_ready) begin
            observed.push_back(m_data);
            assertCount++;
            if (sbQueue.size() == 0) begin
               failCount++;
               $display("[TB] FAIL scoreboard unexpected result: got %0d, expected none", m_data);
            end else begin
               expVal = sbQueue.pop_front();
               if (m_data !== expVal) begin
                  failCount++;
                  $display("[TB] FAIL scoreboard m_data: got %0d, expected %0d", m_data, expVal);
               end
            end
         end
         if (tap_valid) tapPulses++;
         if (s_valid && s_ready) begin
            for (int k = TAPS-1; k > 0; k--) modelTaps[k] = modelTaps[k-1];
            modelTaps[0] = s_data;
            acceptCount++;
            expSum = '0;
            for (int k = 0; k < TAPS; k++) expSum = expSum + OUT_WIDTH'(modelTaps[k]);
`ifdef FIR_WARMUP_EN
            if (acceptCount >= TAPS) sbQueue.push_back(expSum);
`else
            sbQueue.push_back(expSum);
`endif
         end
      end
   end

   task automatic applyReset();
      @(posedge clk); #1;
      rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      observed.delete();
   endtask

   task automatic sendSample(input logic [WIDTH-1:0] v);
      int waited;
      waited = 0;
      s_valid = 1'b1;
      s_data  = v;
      @(negedge clk);
      while (!s_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!s_ready) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL sendSample timeout: s_ready got %0b, expected 1", s_ready);
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic drainScoreboard();
      int n;
      n = 0;
      while (sbQueue.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      assertCount++;
      if (sbQueue.size() != 0) begin
         failCount++;
         $display("[TB] FAIL drain: pending results got %0d, expected 0", sbQueue.size());
      end
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      assertCount++;
      if (s_ready !== 1'b0) begin failCount++; $display("[TB] FAIL reset s_ready: got %0b, expected 0", s_ready); end
      assertCount++;
      if (m_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset m_valid: got %0b, expected 0", m_valid); end
      assertCount++;
      if (tap_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset tap_valid: got %0b, expected 0", tap_valid); end
      assertCount++;
      if (taps !== '0) begin failCount++; $display("[TB] FAIL reset taps: got %0h, expected 0", taps); end
      assertCount++;
      if (m_data !== '0) begin failCount++; $display("[TB] FAIL reset m_data: got %0d, expected 0", m_data); end
      rst = 1'b0;
      @(posedge clk); #1;
      assertCount++;
      if (s_ready !== 1'b1) begin failCount++; $display("[TB] FAIL release s_ready: got %0b, expected 1", s_ready); end
   endtask

   task automatic test_stream();
      logic [OUT_WIDTH-1:0] expSeq[6];
      expSeq = '{1, 3, 6, 10, 15, 21};
      applyReset();
      m_ready = 1'b1;
      for (int v = 1; v <= 6; v++) sendSample(WIDTH'(v));
      drainScoreboard();
      assertCount++;
      if (observed.size() != 6) begin
         failCount++;
         $display("[TB] FAIL stream count: got %0d, expected 6", observed.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            assertCount++;
            if (observed[i] !== expSeq[i]) begin failCount++; $display("[TB] FAIL stream result %0d: got %0d, expected %0d", i, observed[i], expSeq[i]); end
         end
      end
      for (int k = 0; k < TAPS; k++) begin
         assertCount++;
         if (tapSlice(k) !== WIDTH'(6 - k)) begin failCount++; $display("[TB] FAIL stream tap %0d: got %0d, expected %0d", k, tapSlice(k), 6 - k); end
      end
   endtask

   task automatic test_latency();
      applyReset();
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_data  = WIDTH'(7);
      @(negedge clk);
      assertCount++;
      if (s_ready !== 1'b1) begin failCount++; $display("[TB] FAIL latency accept s_ready: got %0b, expected 1", s_ready); end
      @(posedge clk); #1;
      s_valid = 1'b0;
      assertCount++;
      if (tap_valid !== 1'b1) begin failCount++; $display("[TB] FAIL latency tap_valid: got %0b, expected 1", tap_valid); end
      assertCount++;
      if (s_ready !== 1'b0) begin failCount++; $display("[TB] FAIL latency s_ready T+1: got %0b, expected 0", s_ready); end
      for (int k = 1; k < LAT; k++) begin
         @(posedge clk); #1;
         assertCount++;
         if (m_valid !== 1'b0 || s_ready !== 1'b0 || tap_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL latency wait cycle %0d: got m_valid=%0b s_ready=%0b tap_valid=%0b, expected 0 0 0", k, m_valid, s_ready, tap_valid);
         end
      end
      @(posedge clk); #1;
      assertCount++;
      if (m_valid !== 1'b1 || m_data !== OUT_WIDTH'(7)) begin
         failCount++;
         $display("[TB] FAIL latency result: got m_valid=%0b m_data=%0d, expected 1 7", m_valid, m_data);
      end
      assertCount++;
      if (s_ready !== 1'b0) begin failCount++; $display("[TB] FAIL latency hold s_ready: got %0b, expected 0", s_ready); end
      m_ready = 1'b1;
      @(posedge clk); #1;
      assertCount++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL latency release: got m_valid=%0b s_ready=%0b, expected 0 1", m_valid, s_ready);
      end
      drainScoreboard();
   endtask

   task automatic test_backpressure();
      int n;
      applyReset();
      m_ready = 1'b0;
      sendSample(WIDTH'(4));
      n = 0;
      while (!m_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      assertCount++;
      if (m_valid !== 1'b1) begin failCount++; $display("[TB] FAIL backpressure m_valid timeout: got %0b, expected 1", m_valid); end
      s_valid = 1'b1;
      s_data  = WIDTH'(9);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         assertCount++;
         if (m_valid !== 1'b1 || m_data !== OUT_WIDTH'(4) || s_ready !== 1'b0 || tapSlice(0) !== WIDTH'(4)) begin
            failCount++;
            $display("[TB] FAIL backpressure hold %0d: got m_valid=%0b m_data=%0d s_ready=%0b tap0=%0d, expected 1 4 0 4", c, m_valid, m_data, s_ready, tapSlice(0));
         end
      end
      m_ready = 1'b1;
      @(negedge clk);
      assertCount++;
      if (s_ready !== 1'b1) begin failCount++; $display("[TB] FAIL backpressure take s_ready: got %0b, expected 1", s_ready); end
      @(posedge clk); #1;
      s_valid = 1'b0;
      assertCount++;
      if (tap_valid !== 1'b1 || tapSlice(0) !== WIDTH'(9) || tapSlice(1) !== WIDTH'(4) || m_valid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL backpressure same-cycle accept: got tap_valid=%0b tap0=%0d tap1=%0d m_valid=%0b, expected 1 9 4 0", tap_valid, tapSlice(0), tapSlice(1), m_valid);
      end
      drainScoreboard();
      assertCount++;
      if (observed.size() != 2 || observed[observed.size()-1] !== OUT_WIDTH'(13)) begin
         failCount++;
         $display("[TB] FAIL backpressure second result: got count=%0d, expected 2 results ending in 13", observed.size());
      end
   endtask

   task automatic test_wrap();
      applyReset();
      m_ready = 1'b1;
      for (int v = 1; v <= 8; v++) sendSample(WIDTH'(v));
      drainScoreboard();
      assertCount++;
      if (observed.size() != 8 || observed[observed.size()-1] !== OUT_WIDTH'(33)) begin
         failCount++;
         $display("[TB] FAIL wrap 8th result: got count=%0d, expected 8 results ending in 33", observed.size());
      end
      for (int k = 0; k < TAPS; k++) begin
         assertCount++;
         if (tapSlice(k) !== WIDTH'(8 - k)) begin failCount++; $display("[TB] FAIL wrap tap %0d: got %0d, expected %0d", k, tapSlice(k), 8 - k); end
      end
   endtask

   task automatic test_reset_mid();
      applyReset();
      m_ready = 1'b1;
      sendSample(WIDTH'(5));
      drainScoreboard();
      sendSample(WIDTH'(5));
      rst = 1'b1;
      for (int c = 0; c < LAT + 3; c++) begin
         @(posedge clk); #1;
         assertCount++;
         if (m_valid !== 1'b0 || taps !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_mid cycle %0d: got m_valid=%0b taps=%0h, expected 0 0", c, m_valid, taps);
         end
      end
      rst = 1'b0;
      observed.delete();
      sendSample(WIDTH'(2));
      drainScoreboard();
      assertCount++;
      if (observed.size() != 1 || observed[0] !== OUT_WIDTH'(2)) begin
         failCount++;
         $display("[TB] FAIL reset_mid next result: got count=%0d, expected one result of 2", observed.size());
      end
   endtask

   task automatic test_warmup();
      applyReset();
      tapPulses = 0;
      m_ready = 1'b1;
      for (int v = 1; v <= 7; v++) sendSample(WIDTH'(v));
      drainScoreboard();
      repeat (LAT + 3) @(posedge clk);
      #1;
      assertCount++;
      if (observed.size() != 2) begin
         failCount++;
         $display("[TB] FAIL warmup result count: got %0d, expected 2", observed.size());
      end else begin
         assertCount++;
         if (observed[0] !== OUT_WIDTH'(21) || observed[1] !== OUT_WIDTH'(27)) begin
            failCount++;
            $display("[TB] FAIL warmup results: got %0d %0d, expected 21 27", observed[0], observed[1]);
         end
      end
      assertCount++;
      if (tapPulses != 7) begin failCount++; $display("[TB] FAIL warmup tap_valid pulses: got %0d, expected 7", tapPulses); end
   endtask

   initial begin
      test_reset();
`ifdef FIR_WARMUP_EN
      test_warmup();
`else
      test_stream();
      test_latency();
      test_backpressure();
      test_wrap();
      test_reset_mid();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
